button_events: RTL and testbench

Multi-channel button front end that supersedes the single-button debounce and reset-pulse logic in the board top level. For each of `CHANNELS` raw pushbutton inputs it synchronises, debounces and classifies activity into press, release, long-press and auto-repeat events. Events go out two ways: per-channel one-cycle pulses, and a single arbitrated valid/ready event stream for the calculator controller. It sits between the board pins and the controller/LCD path.

---
 rtl/button_events_pkg.sv | 28 ++
 rtl/button_channel.sv | 114 +++++++++++
 rtl/button_events.sv | 105 ++++++++++
 tb/tb_button_events.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_events_pkg.sv
// Shared types and constants for the multi-channel button front end.
package button_events_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int NUM_KINDS = 4;

    // Within one channel, rank 0 is served first: PRESS > LONG > REPEAT > RELEASE.
    localparam logic [7:0] KIND_PRIORITY = {EVT_RELEASE, EVT_REPEAT, EVT_LONG, EVT_PRESS};

    function automatic evt_kind_t prio_kind(input int rank);
        logic [7:0] order;
        order = KIND_PRIORITY;
        return evt_kind_t'(order[rank*2 +: 2]);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce counter and hold FSM with
// registered one-cycle press/release/long/repeat strobes.
module button_channel
    import button_events_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output btn_state_t state
);

    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic              sync_q1, sync_q2;
    logic              level;
    logic              db_toggle;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= IDLE_LEVEL;
            sync_q2 <= IDLE_LEVEL;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    assign level = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    // The counter sits one below the threshold on the D-th differing cycle,
    // so the debounced level flips exactly DEBOUNCE_CYCLES after the sync.
    assign db_toggle = (level != pressed) && (db_cnt == DB_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
        end else if (level == pressed || db_toggle) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign hold_inc = (hold_cnt == {HOLD_W{1'b1}}) ? hold_cnt : hold_cnt + HOLD_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pressed       <= 1'b0;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (db_toggle) begin
                pressed  <= ~pressed;
                hold_cnt <= '0;
                if (pressed) begin
                    state         <= ST_IDLE;
                    release_pulse <= 1'b1;
                end else begin
                    state       <= ST_HELD;
                    press_pulse <= 1'b1;
                end
            end else begin
                case (state)
                    ST_HELD: begin
                        if (hold_cnt == LONG_LAST) begin
                            state      <= ST_REPEAT;
                            long_pulse <= 1'b1;
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (REPEAT_CYCLES != 0 && hold_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_inc;
                        end
                    end
                    default: hold_cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/button_events.sv
// Button front end: per-channel strobes plus a pending store and a
// priority-arbitrated valid/ready event slot.
module button_events
    import button_events_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   btn_in,
    output logic [CHANNELS-1:0]   pressed,
    output logic [CHANNELS-1:0]   press_pulse,
    output logic [CHANNELS-1:0]   release_pulse,
    output logic [CHANNELS-1:0]   long_pulse,
    output logic [CHANNELS-1:0]   repeat_pulse,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CW-1:0]         evt_chan,
    output evt_kind_t             evt_kind,
    output logic                  evt_overflow,
    output logic [2*CHANNELS-1:0] chan_state
);

    localparam int NBITS = CHANNELS * NUM_KINDS;
    localparam int IDX_W = $clog2(NBITS);

    // Pending bit for (channel c, kind k) lives at c*NUM_KINDS + k.
    logic [NBITS-1:0] set_vec, pend, clr_vec;
    logic             found, load;
    logic [CW-1:0]    win_chan;
    evt_kind_t        win_kind, k;
    logic [IDX_W-1:0] win_idx;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clock         (clock),
            .reset_n       (reset_n),
            .btn_in        (btn_in[g]),
            .pressed       (pressed[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_pulse    (long_pulse[g]),
            .repeat_pulse  (repeat_pulse[g]),
            .state         (chan_state[2*g +: 2])
        );
        assign set_vec[g*NUM_KINDS + int'(EVT_PRESS)]   = press_pulse[g];
        assign set_vec[g*NUM_KINDS + int'(EVT_RELEASE)] = release_pulse[g];
        assign set_vec[g*NUM_KINDS + int'(EVT_LONG)]    = long_pulse[g];
        assign set_vec[g*NUM_KINDS + int'(EVT_REPEAT)]  = repeat_pulse[g];
    end

    always_comb begin
        found    = 1'b0;
        win_chan = '0;
        win_kind = EVT_PRESS;
        win_idx  = '0;
        k        = EVT_PRESS;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < NUM_KINDS; r++) begin
                k = prio_kind(r);
                if (!found && pend[c*NUM_KINDS + int'(k)]) begin
                    found    = 1'b1;
                    win_chan = CW'(c);
                    win_kind = k;
                    win_idx  = IDX_W'(c*NUM_KINDS + int'(k));
                end
            end
        end
        load    = found && (!evt_valid || evt_ready);
        clr_vec = '0;
        if (load) clr_vec[win_idx] = 1'b1;
    end

    // A set that collides with its own clear keeps the bit and is not a loss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend         <= '0;
            evt_valid    <= 1'b0;
            evt_chan     <= '0;
            evt_kind     <= EVT_PRESS;
            evt_overflow <= 1'b0;
        end else begin
            pend <= (pend & ~clr_vec) | set_vec;
            if (|(set_vec & pend & ~clr_vec)) evt_overflow <= 1'b1;
            if (load) begin
                evt_valid <= 1'b1;
                evt_chan  <= win_chan;
                evt_kind  <= win_kind;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Randomised bench for button_events: behavioural timing model, per-cycle
// output checks and an in-order event scoreboard on the valid/ready stream.
module tb_button_events;
    import button_events_pkg::*;

    localparam int CH = 4;
    localparam int D  = 4;
    localparam int L  = 20;
    localparam int R  = 5;
    localparam int CW = 2;
    localparam int EW = CW + 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] btn_in;
    logic          evt_ready;
    logic [CH-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic          evt_valid, evt_overflow;
    logic [CW-1:0] evt_chan;
    logic [1:0]    evt_kind;
    logic [2*CH-1:0] chan_state;

    always #5 clock = ~clock;

    button_events #(
        .CHANNELS(CH), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L), .REPEAT_CYCLES(R)
    ) dut (
        .clock(clock), .reset_n(reset_n), .btn_in(btn_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
        .evt_kind(evt_kind), .evt_overflow(evt_overflow), .chan_state(chan_state)
    );

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model state: sample history, per-channel press times, events.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_db, m_press, m_release, m_long, m_repeat;
    int            press_edge[CH];
    bit            long_done[CH];
    bit            m_pend[CH][4];
    bit            m_valid, m_ovf;
    logic [EW-1:0] m_slot;
    int            cyc;
    int            rank_kind[4] = '{0, 2, 3, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back('0);
        m_db = '0; m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
        for (int c = 0; c < CH; c++) begin
            press_edge[c] = 0;
            long_done[c]  = 0;
            for (int j = 0; j < 4; j++) m_pend[c][j] = 0;
        end
        m_valid = 0; m_ovf = 0; m_slot = '0; cyc = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [CH-1:0] h, n_press, n_release, n_long, n_repeat;
        int wc, wk, d;
        bit set, clr, toggle;
        cyc++;
        wc = -1; wk = 0;
        // output slot: refill when empty or being taken this edge
        if (!m_valid || evt_ready) begin
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < 4; r++)
                    if (wc < 0 && m_pend[c][rank_kind[r]]) begin
                        wc = c; wk = rank_kind[r];
                    end
            if (wc >= 0) begin
                m_valid = 1;
                m_slot  = {CW'(wc), 2'(wk)};
                exp_q.push_back(m_slot);
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < 4; j++) begin
                case (j)
                    0: set = m_press[c];
                    1: set = m_release[c];
                    2: set = m_long[c];
                    default: set = m_repeat[c];
                endcase
                clr = (c == wc) && (j == wk);
                if (set && m_pend[c][j] && !clr) m_ovf = 1;
                m_pend[c][j] = (m_pend[c][j] && !clr) || set;
            end
        n_press = '0; n_release = '0; n_long = '0; n_repeat = '0;
        for (int c = 0; c < CH; c++) begin
            // accept a level once the D samples ending two edges ago all disagree
            toggle = 1;
            for (int j = 0; j < D; j++) begin
                h = hist[hist.size() - 2 - j];
                if (h[c] == m_db[c]) toggle = 0;
            end
            if (toggle) begin
                m_db[c] = ~m_db[c];
                if (m_db[c]) begin
                    n_press[c] = 1; press_edge[c] = cyc; long_done[c] = 0;
                end else begin
                    n_release[c] = 1;
                end
            end else if (m_db[c]) begin
                d = cyc - press_edge[c];
                if (!long_done[c] && d == L) begin
                    n_long[c] = 1; long_done[c] = 1;
                end else if (long_done[c] && R > 0 && d > L && (d - L) % R == 0) begin
                    n_repeat[c] = 1;
                end
            end
        end
        m_press = n_press; m_release = n_release; m_long = n_long; m_repeat = n_repeat;
        hist.push_back(~btn_in);
        if (hist.size() > D + 2) void'(hist.pop_front());
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Per-cycle output checks plus the stream scoreboard.
    always @(negedge clock) begin
        check("pressed", 32'(pressed), 32'(m_db));
        check("press_pulse", 32'(press_pulse), 32'(m_press));
        check("release_pulse", 32'(release_pulse), 32'(m_release));
        check("long_pulse", 32'(long_pulse), 32'(m_long));
        check("repeat_pulse", 32'(repeat_pulse), 32'(m_repeat));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        if (m_valid) check("slot_hold", 32'({evt_chan, evt_kind}), 32'(m_slot));
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("stream_unexpected", 32'({evt_chan, evt_kind}), 32'hFFFF_FFFF);
            end else begin
                check("stream_event", 32'({evt_chan, evt_kind}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Level already driven just after a rising edge; press must land 6 edges later.
    task automatic expect_press(input int ch);
        idle(5);
        @(negedge clock);
        check("press_early", 32'(pressed[ch]), 32'd0);
        tick();
        @(negedge clock);
        check("press_at_t6", 32'({pressed[ch], press_pulse[ch]}), 32'd3);
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_in    = 4'($urandom);
        evt_ready = 1'b1;
        idle(3);
        @(negedge clock);
        check("reset_outputs", 32'({pressed, press_pulse, release_pulse, long_pulse,
              repeat_pulse, evt_valid, evt_overflow, evt_chan, evt_kind}), 32'd0);
        tick();
        btn_in = '1;
        tick();
        reset_n = 1'b1;
        idle(20);

        // bounce shorter than the debounce window, then a clean press on ch0
        btn_in[0] = 1'b0;
        idle(3);
        btn_in[0] = 1'b1;
        idle(15);
        check("bounce_ignored", 32'(pressed[0]), 32'd0);
        btn_in[0] = 1'b0;
        expect_press(0);
        tick();
        @(negedge clock);
        check("evt_not_yet", 32'(evt_valid), 32'd0);
        tick();
        @(negedge clock);
        check("evt_at_t8", 32'({evt_valid, evt_chan, evt_kind}), 32'({1'b1, 2'd0, EVT_PRESS}));
        tick();
        btn_in[0] = 1'b1;
        idle(15);

        // long hold on ch1: long then repeats, then release
        btn_in[1] = 1'b0;
        idle(6 + 40);
        btn_in[1] = 1'b1;
        idle(20);

        // simultaneous presses under stall
        evt_ready = 1'b0;
        btn_in[0] = 1'b0;
        btn_in[2] = 1'b0;
        idle(10);
        @(negedge clock);
        check("stall_slot", 32'({evt_valid, evt_chan, evt_kind}), 32'({1'b1, 2'd0, EVT_PRESS}));
        tick();
        idle(3);
        @(negedge clock);
        check("stall_stable", 32'({evt_chan, evt_kind}), 32'({2'd0, EVT_PRESS}));
        tick();
        evt_ready = 1'b1;
        idle(3);
        btn_in[0] = 1'b1;
        btn_in[2] = 1'b1;
        idle(30);

        // overflow: repeated press/release on ch3 while stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_in[3] = 1'b0;
            idle(8);
            btn_in[3] = 1'b1;
            idle(8);
        end
        @(negedge clock);
        check("overflow_set", 32'(evt_overflow), 32'd1);
        tick();
        evt_ready = 1'b1;
        idle(15);

        // reset while ch1 is auto-repeating
        btn_in[1] = 1'b0;
        idle(6 + L + 3);
        reset_n = 1'b0;
        #1;
        check("reset_async", 32'({pressed, long_pulse, repeat_pulse, evt_valid, evt_overflow}), 32'd0);
        tick();
        reset_n = 1'b1;
        expect_press(1);
        idle(10);
        btn_in[1] = 1'b1;
        idle(15);

        // random levels and back-pressure
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, CH - 1);
                btn_in[b] = ~btn_in[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        btn_in    = '1;
        evt_ready = 1'b1;
        idle(60);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
